// File: rtl/ex_mem_stage_pkg.sv
// Shared definitions for the execute/memory boundary: word size, ALU branch
// flag codes, branch funct3 codes and the layout of a buffered beat.
package ex_mem_stage_pkg;

  localparam int WORDSIZE = 32;

  localparam logic [1:0] ALU_BR_EQ = 2'd0;
  localparam logic [1:0] ALU_BR_LT = 2'd1;
  localparam logic [1:0] ALU_BR_GT = 2'd2;

  localparam logic [2:0] FUNCT_BEQ  = 3'b000;
  localparam logic [2:0] FUNCT_BNE  = 3'b001;
  localparam logic [2:0] FUNCT_BLT  = 3'b100;
  localparam logic [2:0] FUNCT_BGE  = 3'b101;
  localparam logic [2:0] FUNCT_BLTU = 3'b110;
  localparam logic [2:0] FUNCT_BGEU = 3'b111;

  // Beat payload {alu, rs2, rd, reg_write, mem_read, mem_write}, LSB first offsets.
  localparam int OFF_MW    = 0;
  localparam int OFF_MR    = 1;
  localparam int OFF_RW    = 2;
  localparam int OFF_RD    = 3;
  localparam int OFF_RS2   = 8;
  localparam int OFF_ALU   = OFF_RS2 + WORDSIZE;
  localparam int PAYLOAD_W = OFF_ALU + WORDSIZE;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_t;

endpackage

// File: rtl/ex_mem_stage_br_cond.sv
// Combinational branch-condition decode: maps funct3 plus the ALU compare
// flag to a taken bit. Unused funct3 encodings are never taken.
module br_cond
  import ex_mem_stage_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [1:0] alu_br_ops,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      FUNCT_BEQ:  taken = (alu_br_ops == ALU_BR_EQ);
      FUNCT_BNE:  taken = (alu_br_ops != ALU_BR_EQ);
      FUNCT_BLT,
      FUNCT_BLTU: taken = (alu_br_ops == ALU_BR_LT);
      FUNCT_BGE,
      FUNCT_BGEU: taken = (alu_br_ops == ALU_BR_EQ) || (alu_br_ops == ALU_BR_GT);
      default:    taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// Execute-to-memory pipeline register built as a two-entry skid buffer with
// registered ready, plus a one-cycle taken-branch redirect pulse.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WORDSIZE-1:0] alu_out,
  input  logic [1:0]          alu_br_ops,
  input  logic                is_branch,
  input  logic [2:0]          funct3,
  input  logic [WORDSIZE-1:0] pc,
  input  logic [WORDSIZE-1:0] imm,
  input  logic [WORDSIZE-1:0] rs2_data,
  input  logic [4:0]          rd,
  input  logic                reg_write,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORDSIZE-1:0] out_alu,
  output logic [WORDSIZE-1:0] out_rs2,
  output logic [4:0]          out_rd,
  output logic                out_reg_write,
  output logic                out_mem_read,
  output logic                out_mem_write,
  output logic                redirect,
  output logic [WORDSIZE-1:0] redirect_pc
);

  generate
    if (DEPTH != 2) begin : g_depth_check
      $error("ex_mem_stage: only DEPTH=2 is supported");
    end
  endgenerate

  buf_state_t           state_reg;
  logic [PAYLOAD_W-1:0] head_reg;
  logic [PAYLOAD_W-1:0] tail_reg;
  logic                 redirect_reg;
  logic [WORDSIZE-1:0]  redirect_pc_reg;

  logic [2:0]           ctrl_raw;
  logic [2:0]           ctrl_next;
  logic [PAYLOAD_W-1:0] in_entry_next;
  logic [WORDSIZE-1:0]  target_next;
  logic                 taken;
  logic                 accept;
  logic                 issue;

  // Branches never write registers or touch memory downstream.
  assign ctrl_raw = {reg_write, mem_read, mem_write};
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_ctrl_mask
      assign ctrl_next[gi] = ctrl_raw[gi] & ~is_branch;
    end
  endgenerate

  assign in_entry_next = {alu_out, rs2_data, rd, ctrl_next};
  assign target_next   = pc + imm;

  br_cond u_br_cond (
    .funct3     (funct3),
    .alu_br_ops (alu_br_ops),
    .taken      (taken)
  );

  assign in_ready  = (state_reg != BUF_TWO);
  assign out_valid = (state_reg != BUF_EMPTY);
  assign accept    = in_valid & in_ready;
  assign issue     = out_valid & out_ready;

  // head_reg is the oldest entry and drives the outputs directly; it is zeroed
  // whenever the buffer drains so control bits read 0 while out_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= BUF_EMPTY;
      head_reg        <= '0;
      tail_reg        <= '0;
      redirect_reg    <= 1'b0;
      redirect_pc_reg <= '0;
    end else if (flush) begin
      state_reg    <= BUF_EMPTY;
      head_reg     <= '0;
      redirect_reg <= 1'b0;
    end else begin
      redirect_reg <= accept & is_branch & taken;
      if (accept & is_branch & taken) begin
        redirect_pc_reg <= target_next;
      end
      case (state_reg)
        BUF_EMPTY: begin
          if (accept) begin
            head_reg  <= in_entry_next;
            state_reg <= BUF_ONE;
          end
        end
        BUF_ONE: begin
          if (accept && issue) begin
            head_reg <= in_entry_next;
          end else if (accept) begin
            tail_reg  <= in_entry_next;
            state_reg <= BUF_TWO;
          end else if (issue) begin
            head_reg  <= '0;
            state_reg <= BUF_EMPTY;
          end
        end
        BUF_TWO: begin
          if (issue) begin
            head_reg  <= tail_reg;
            state_reg <= BUF_ONE;
          end
        end
        default: begin
          head_reg  <= '0;
          state_reg <= BUF_EMPTY;
        end
      endcase
    end
  end

  assign out_alu       = head_reg[OFF_ALU +: WORDSIZE];
  assign out_rs2       = head_reg[OFF_RS2 +: WORDSIZE];
  assign out_rd        = head_reg[OFF_RD +: 5];
  assign out_reg_write = head_reg[OFF_RW];
  assign out_mem_read  = head_reg[OFF_MR];
  assign out_mem_write = head_reg[OFF_MW];
  assign redirect      = redirect_reg;
  assign redirect_pc   = redirect_pc_reg;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: table of beats with hand-derived branch outcomes,
// a queue scoreboard for FIFO order, and hand sequences for corner cases.
module tb_ex_mem_stage;
  import ex_mem_stage_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_valid, in_ready, is_branch, reg_write, mem_read, mem_write, flush;
  logic out_valid, out_ready, out_reg_write, out_mem_read, out_mem_write, redirect;
  logic [1:0]  alu_br_ops;
  logic [2:0]  funct3;
  logic [4:0]  rd, out_rd;
  logic [31:0] alu_out, pc, imm, rs2_data, out_alu, out_rs2, redirect_pc;

  ex_mem_stage #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_out(alu_out), .alu_br_ops(alu_br_ops), .is_branch(is_branch),
    .funct3(funct3), .pc(pc), .imm(imm), .rs2_data(rs2_data), .rd(rd),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_alu(out_alu), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  typedef struct {
    logic        rst, in_valid, out_ready, flush, is_branch;
    logic [2:0]  funct3;
    logic [1:0]  br;
    logic [31:0] pc, imm, alu, rs2;
    logic [4:0]  rd;
    logic        rw, mr, mw;
    logic        exp_taken;
    logic [31:0] exp_target;
  } vec_t;

  typedef struct packed {
    logic [31:0] alu, rs2;
    logic [4:0]  rd;
    logic        rw, mr, mw;
  } exp_t;

  exp_t        q[$];
  int          n_vec = 0;
  int          n_miss = 0;
  logic        mon_on = 1'b0;
  logic        cur_taken = 1'b0;
  logic [31:0] cur_target = '0;
  logic        exp_redir = 1'b0;
  logic [31:0] exp_redir_pc = '0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor at the falling edge: check DUT against the model, then predict the next edge.
  always @(negedge clk) begin
    logic acc, iss;
    exp_t e;
    if (mon_on) begin
      chk1("out_valid", out_valid, q.size() != 0);
      chk1("in_ready", in_ready, q.size() != 2);
      chk1("redirect", redirect, exp_redir);
      if (exp_redir) chk32("redirect_pc", redirect_pc, exp_redir_pc);
      if (q.size() != 0) begin
        chk32("out_alu", out_alu, q[0].alu);
        chk32("out_rs2", out_rs2, q[0].rs2);
        chk32("out_rd", {27'd0, out_rd}, {27'd0, q[0].rd});
        chk32("out_ctrl", {29'd0, out_reg_write, out_mem_read, out_mem_write},
              {29'd0, q[0].rw, q[0].mr, q[0].mw});
      end else begin
        chk32("idle_ctrl", {29'd0, out_reg_write, out_mem_read, out_mem_write}, 32'd0);
      end
    end
    acc = in_valid && (q.size() != 2);
    iss = out_ready && (q.size() != 0);
    if (rst || flush) begin
      q.delete();
      exp_redir = 1'b0;
    end else begin
      exp_redir    = acc && is_branch && cur_taken;
      exp_redir_pc = cur_target;
      if (iss) begin
        $display("issue alu=%h rs2=%h rd=%0d ctrl=%b%b%b", q[0].alu, q[0].rs2, q[0].rd,
                 q[0].rw, q[0].mr, q[0].mw);
        void'(q.pop_front());
      end
      if (acc) begin
        e.alu = alu_out; e.rs2 = rs2_data; e.rd = rd;
        e.rw  = reg_write & ~is_branch;
        e.mr  = mem_read  & ~is_branch;
        e.mw  = mem_write & ~is_branch;
        q.push_back(e);
      end
    end
  end

  task automatic apply(input vec_t v);
    rst = v.rst; in_valid = v.in_valid; out_ready = v.out_ready; flush = v.flush;
    is_branch = v.is_branch; funct3 = v.funct3; alu_br_ops = v.br;
    pc = v.pc; imm = v.imm; alu_out = v.alu; rs2_data = v.rs2; rd = v.rd;
    reg_write = v.rw; mem_read = v.mr; mem_write = v.mw;
    cur_taken = v.exp_taken; cur_target = v.exp_target;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t nb(input logic [31:0] alu, input logic valid, input logic ordy);
    vec_t v;
    v = '{rst:0, in_valid:valid, out_ready:ordy, flush:0, is_branch:0, funct3:3'b000,
          br:ALU_BR_EQ, pc:32'h0, imm:32'h0, alu:alu, rs2:alu ^ 32'hA5A5_0000,
          rd:alu[4:0], rw:1, mr:0, mw:0, exp_taken:0, exp_target:32'h0};
    return v;
  endfunction

  function automatic vec_t br(input logic [2:0] f3, input logic [1:0] flag, input logic [31:0] p,
                              input logic [31:0] i, input logic tk, input logic [31:0] tgt);
    vec_t v;
    v = nb(p ^ 32'h77, 1'b1, 1'b1);
    v.is_branch = 1'b1; v.funct3 = f3; v.br = flag; v.pc = p; v.imm = i;
    v.mr = 1'b1; v.mw = 1'b1;
    v.exp_taken = tk; v.exp_target = tgt;
    return v;
  endfunction

  vec_t tbl[15];
  vec_t v;

  initial begin
    tbl[0]  = nb(32'h0000_0011, 1, 1);
    tbl[1]  = br(FUNCT_BEQ,  ALU_BR_EQ, 32'h0000_0100, 32'h0000_0020, 1, 32'h0000_0120);
    tbl[2]  = br(FUNCT_BNE,  ALU_BR_EQ, 32'h0000_0140, 32'h0000_0004, 0, 32'h0);
    tbl[3]  = br(FUNCT_BNE,  ALU_BR_LT, 32'h0000_0200, 32'h0000_0008, 1, 32'h0000_0208);
    tbl[4]  = br(FUNCT_BLT,  ALU_BR_LT, 32'h0000_0300, 32'hFFFF_FFFC, 1, 32'h0000_02FC);
    tbl[5]  = br(FUNCT_BLTU, ALU_BR_GT, 32'h0000_0400, 32'h0000_0010, 0, 32'h0);
    tbl[6]  = br(FUNCT_BGE,  ALU_BR_LT, 32'h0000_0500, 32'h0000_0010, 0, 32'h0);
    tbl[7]  = br(FUNCT_BGE,  ALU_BR_GT, 32'h0000_0010, 32'h0000_0010, 1, 32'h0000_0020);
    tbl[8]  = br(FUNCT_BGEU, ALU_BR_EQ, 32'hFFFF_FFF0, 32'h0000_0020, 1, 32'h0000_0010);
    tbl[9]  = br(3'b010,     ALU_BR_EQ, 32'h0000_0600, 32'h0000_0010, 0, 32'h0);
    tbl[10] = br(3'b011,     ALU_BR_GT, 32'h0000_0700, 32'h0000_0010, 0, 32'h0);
    tbl[11] = nb(32'h0000_1000, 1, 1); tbl[11].rw = 0; tbl[11].mw = 1; tbl[11].rs2 = 32'hDEAD_BEEF;
    tbl[12] = nb(32'h0000_2000, 1, 0); tbl[12].rw = 1; tbl[12].mr = 1;
    tbl[13] = br(FUNCT_BLT,  ALU_BR_EQ, 32'h0000_0800, 32'h0000_0010, 0, 32'h0);
    tbl[14] = br(FUNCT_BLTU, ALU_BR_LT, 32'h0000_0900, 32'h0000_0100, 1, 32'h0000_0A00);
    tbl[13].out_ready = 1'b0;

    // Reset: two cycles, everything quiet.
    v = nb(32'h0, 0, 0); v.rst = 1'b1;
    rst = 1; in_valid = 0; out_ready = 0; flush = 0; is_branch = 0; funct3 = 0;
    alu_br_ops = 0; pc = 0; imm = 0; alu_out = 0; rs2_data = 0; rd = 0;
    reg_write = 0; mem_read = 0; mem_write = 0;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_redirect", redirect, 1'b0);
    chk32("rst_redirect_pc", redirect_pc, 32'h0);
    chk32("rst_out_alu", out_alu, 32'h0);
    chk32("rst_out_rs2", out_rs2, 32'h0);
    chk32("rst_out_rd", {27'd0, out_rd}, 32'h0);
    chk32("rst_ctrl", {29'd0, out_reg_write, out_mem_read, out_mem_write}, 32'h0);
    mon_on = 1'b1;
    apply(v);

    for (int i = 0; i < 15; i++) apply(tbl[i]);
    repeat (3) apply(nb(32'h0, 0, 1));

    // Backpressure: third beat must wait until the buffer drains.
    apply(nb(32'h1, 1, 0));
    apply(nb(32'h2, 1, 0));
    chk1("bp_in_ready_full", in_ready, 1'b0);
    repeat (2) apply(nb(32'h3, 1, 0));
    repeat (2) apply(nb(32'h3, 1, 1));
    repeat (2) apply(nb(32'h0, 0, 1));

    // Flush while full with a taken branch offered.
    apply(nb(32'h55, 1, 0));
    apply(nb(32'h66, 1, 0));
    v = br(FUNCT_BEQ, ALU_BR_EQ, 32'h100, 32'h20, 1, 32'h120); v.flush = 1'b1;
    apply(v);
    chk1("flush_out_valid", out_valid, 1'b0);
    chk1("flush_redirect", redirect, 1'b0);
    chk1("flush_in_ready", in_ready, 1'b1);

    // Flush with one entry: the acceptable taken branch is dropped.
    apply(nb(32'h77, 1, 0));
    apply(v);
    chk1("flush1_redirect", redirect, 1'b0);
    chk1("flush1_out_valid", out_valid, 1'b0);
    apply(nb(32'h0, 0, 1));

    // Reset mid-transfer, together with flush, a taken branch and issue.
    apply(nb(32'h88, 1, 0));
    v = br(FUNCT_BNE, ALU_BR_GT, 32'h400, 32'h40, 1, 32'h440);
    v.rst = 1'b1; v.flush = 1'b1;
    apply(v);
    chk1("mrst_out_valid", out_valid, 1'b0);
    chk1("mrst_redirect", redirect, 1'b0);
    chk32("mrst_redirect_pc", redirect_pc, 32'h0);
    chk32("mrst_out_alu", out_alu, 32'h0);
    chk32("mrst_ctrl", {29'd0, out_reg_write, out_mem_read, out_mem_write}, 32'h0);

    // Recovery after reset.
    apply(br(FUNCT_BGE, ALU_BR_EQ, 32'h1000, 32'h8, 1, 32'h1008));
    apply(nb(32'h99, 1, 1));
    repeat (3) apply(nb(32'h0, 0, 1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning skid-buffer entries; only value 2 supported.
REQ-002 SHALL have ports clk (input, 1, rising-edge clock) and rst (input, 1, reset); one clock, reset synchronous active-high.
REQ-003 in_valid  input  1  execute result presented.
REQ-004 in_ready  output  1  stage can accept this cycle.
REQ-005 alu_out  input  WORDSIZE  ALU result.
REQ-006 alu_br_ops  input  2  ALU_BR_EQ / ALU_BR_LT / ALU_BR_GT flag from ALU.
REQ-007 is_branch  input  1  instruction is a conditional branch; funct3 input 3 branch condition.
REQ-008 pc, imm  input  WORDSIZE each  instruction PC and sign-extended immediate.
REQ-009 rs2_data  input  WORDSIZE  store data; rd input 5; reg_write, mem_read, mem_write input 1 each.
REQ-010 flush  input  1  discard all buffered and incoming beats.
REQ-011 out_valid  output  1; out_ready  input  1  memory-stage handshake.
REQ-012 out_alu, out_rs2  output  WORDSIZE; out_rd output 5; out_reg_write, out_mem_read, out_mem_write output 1.
REQ-013 redirect  output  1  one-cycle taken-branch pulse; redirect_pc output WORDSIZE target.

Function
REQ-014 Transfer occurs on in_valid&in_ready (accept) or out_valid&out_ready (issue); no other event moves data.
REQ-015 Buffer states EMPTY, ONE, TWO; EMPTY->ONE on accept; ONE->TWO on accept without issue; ONE->EMPTY on issue without accept; ONE stays ONE on accept+issue; TWO->ONE on issue; TWO never accepts.
REQ-016 in_ready SHALL equal (state != TWO), independent of out_ready (registered, no combinational ready path).
REQ-017 out_valid SHALL equal (state != EMPTY); outputs show oldest entry; order strictly FIFO.
REQ-018 Latency: accepted beat visible on outputs the cycle after accept when buffer was EMPTY.
REQ-019 Branch taken: BEQ=EQ; BNE=!EQ; BLT,BLTU=LT; BGE,BGEU=EQ|GT; funct3 010/011 SHALL give not-taken.
REQ-020 redirect SHALL pulse exactly one cycle, the cycle after accepting is_branch with taken=1; redirect_pc = pc+imm, modulo 2^WORDSIZE (wrap, no overflow flag).
REQ-021 Branch beats SHALL be buffered with reg_write, mem_read, mem_write forced 0.
REQ-022 Not-taken branch or non-branch SHALL leave redirect 0.
REQ-023 flush SHALL set state EMPTY next cycle, drop any same-cycle accept, and suppress redirect for that beat; flush wins over accept and issue.
REQ-024 Outputs SHALL hold stable while out_valid&!out_ready.
REQ-025 Data lines of empty entries are don't-care; control bits (out_reg_write, out_mem_read, out_mem_write) SHALL be 0 when out_valid=0.

Reset
REQ-026 rst SHALL force state EMPTY, in_ready=1 from the next cycle, out_valid=0, redirect=0, redirect_pc=0, all out_* data and control 0.
REQ-027 rst asserted mid-transfer SHALL discard both entries and any pending redirect; rst overrides flush and all handshakes.

Structure
REQ-028 WORDSIZE, ALU_BR_* codes and branch FUNCT_* codes SHALL come from the shared defs.v include; no local redefinition.
REQ-029 Branch-condition decode SHALL be a separate sub-module br_cond (inputs funct3, alu_br_ops; output taken), combinational.
REQ-030 Entry payload SHALL be one packed vector, width defined once as a local constant.

Verification
REQ-031 Reset: rst=1 two cycles -> out_valid=0, in_ready=1, redirect=0, all outputs 0.
REQ-032 Backpressure: out_ready=0, three beats offered (alu_out 1,2,3) -> beats 1,2 accepted, in_ready=0 after second; out_ready=1 -> issue order 1,2 then 3 accepted and issued.
REQ-033 Branch: is_branch=1, funct3=BEQ, alu_br_ops=EQ, pc=0x100, imm=0x20 -> redirect=1 one cycle, redirect_pc=0x120, out_reg_write=0.
REQ-034 Not taken: funct3=BGE, alu_br_ops=LT -> redirect stays 0, beat still issued.
REQ-035 Wrap: pc=0xFFFF_FFF0, imm=0x20, taken -> redirect_pc=0x0000_0010.
REQ-036 Flush: state TWO, flush=1 with in_valid=1 and taken branch -> next cycle out_valid=0, redirect=0, in_ready=1.
